// File: rtl/layer00_pkg.sv
// Shared parameters, weight table, FSM encoding and the ReLU/saturation helper
// for the layer-0 convolution engine.
package layer00_pkg;

  localparam int NUM_BANK   = 16;
  localparam int BANK_DEPTH = 512;
  localparam int SCAN_DEPTH = 128;
  localparam int DATA_W     = 128;
  localparam int PIX_W      = 8;
  localparam int NUM_CH     = 4;
  localparam int SHIFT      = 7;
  localparam int BIAS_W     = 16;
  localparam int ACC_W      = 21;
  localparam int SUM_W      = 22;

  localparam int NUM_PIX  = DATA_W / PIX_W;
  localparam int BANK_AW  = $clog2(BANK_DEPTH);
  localparam int SCAN_AW  = $clog2(SCAN_DEPTH);
  localparam int BANK_SW  = $clog2(NUM_BANK);
  localparam int CNT_W    = BANK_SW + SCAN_AW;
  localparam int TOTAL_RD = NUM_BANK * SCAN_DEPTH;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic signed [7:0] W [NUM_CH][NUM_PIX] = '{
    '{ 8'sd127,  8'sd100,  8'sd90,   8'sd80,   8'sd70,   8'sd60,   8'sd50,   8'sd40,
       8'sd30,   8'sd20,   8'sd10,   8'sd5,    8'sd3,    8'sd2,    8'sd1,    8'sd127 },
    '{ 8'sh80,  -8'sd100, -8'sd64,  -8'sd32,  -8'sd16,  -8'sd8,   -8'sd4,   -8'sd2,
      -8'sd1,    8'sd1,    8'sd2,    8'sd4,    8'sd8,    8'sd16,   8'sd32,   8'sd64  },
    '{ 8'sd64,  -8'sd32,   8'sd48,  -8'sd16,   8'sd24,  -8'sd8,    8'sd12,  -8'sd4,
       8'sd6,   -8'sd2,    8'sd3,   -8'sd1,    8'sd2,   -8'sd1,    8'sd1,   -8'sd1  },
    '{ 8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,
       8'sh80,   8'sh80,   8'sh80,   8'sh80,   8'sd64,   8'sd64,   8'sd32,   8'sd16  }
  };

  // Negative results clip to zero, anything above the pixel range clips to 255.
  function automatic logic [PIX_W-1:0] relu_sat(input sum_t s);
    if (s < sum_t'(0))        return '0;
    else if (s > sum_t'(255)) return '1;
    else                      return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/layer00_bram.sv
// Simple dual-port block RAM: one synchronous write port, one registered read port.
module layer00_bram
  import layer00_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [BANK_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic               i_re,
  input  logic [BANK_AW-1:0] i_raddr,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [DATA_W-1:0] r_mem [BANK_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so synthesis can map it onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/layer00_conv.sv
// Layer-0 convolution: scans 16 pixel banks, applies a 4-channel 16-tap MAC with
// bias, arithmetic shift, ReLU and saturation, one result per cycle.
module layer00_conv
  import layer00_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     iStart,
  input  logic [NUM_BANK-1:0]      i_ena,
  input  logic [BANK_AW-1:0]       i_addra,
  input  logic [NUM_BANK-1:0]      i_wea,
  input  logic [DATA_W-1:0]        i_dia,
  input  logic signed [BIAS_W-1:0] iBias0,
  input  logic signed [BIAS_W-1:0] iBias1,
  input  logic signed [BIAS_W-1:0] iBias2,
  input  logic signed [BIAS_W-1:0] iBias3,
  output logic [PIX_W-1:0]         oLayer0_0,
  output logic [PIX_W-1:0]         oLayer0_1,
  output logic [PIX_W-1:0]         oLayer0_2,
  output logic [PIX_W-1:0]         oLayer0_3,
  output logic                     oValid,
  output logic                     oDone
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_issued;
  logic                r_rd_vld;
  logic                r_valid;
  logic                r_done;
  logic [BANK_SW-1:0]  r_bank_sel;
  logic [PIX_W-1:0]    r_out [NUM_CH];

  logic                     w_rd_en;
  logic [BANK_SW-1:0]       w_bank;
  logic [BANK_AW-1:0]       w_raddr;
  logic [DATA_W-1:0]        w_dout [NUM_BANK];
  logic [DATA_W-1:0]        w_rd_data;
  logic signed [BIAS_W-1:0] w_bias [NUM_CH];
  acc_t                     w_acc [NUM_CH];
  sum_t                     w_shf [NUM_CH];

  assign w_bias[0] = iBias0;
  assign w_bias[1] = iBias1;
  assign w_bias[2] = iBias2;
  assign w_bias[3] = iBias3;

  // The scan counter is {bank, address}; only the low SCAN_DEPTH words are read.
  assign w_rd_en   = (r_state == S_RUN) && !r_issued;
  assign w_bank    = r_cnt[CNT_W-1:SCAN_AW];
  assign w_raddr   = BANK_AW'(r_cnt[SCAN_AW-1:0]);
  assign w_rd_data = w_dout[r_bank_sel];

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    layer00_bram u_bram (
      .clk     (clk),
      .i_we    (i_ena[b] & i_wea[b]),
      .i_waddr (i_addra),
      .i_wdata (i_dia),
      .i_re    (w_rd_en && (w_bank == BANK_SW'(b))),
      .i_raddr (w_raddr),
      .o_rdata (w_dout[b])
    );
  end

  // NOTE: every element is assigned before any branch so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_acc[c] = '0;
      for (int p = 0; p < NUM_PIX; p++) begin
        w_acc[c] = w_acc[c]
                 + acc_t'($signed({1'b0, w_rd_data[p*PIX_W +: PIX_W]})) * acc_t'(W[c][p]);
      end
      w_shf[c] = (sum_t'(w_acc[c]) + sum_t'(w_bias[c])) >>> SHIFT;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_issued   <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_bank_sel <= '0;
      for (int c = 0; c < NUM_CH; c++) r_out[c] <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_valid  <= r_rd_vld;
      if (w_rd_en) r_bank_sel <= w_bank;
      if (r_rd_vld) begin
        for (int c = 0; c < NUM_CH; c++) r_out[c] <= relu_sat(w_shf[c]);
      end

      unique case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_issued <= 1'b0;
          end
        end
        S_RUN: begin
          if (!r_issued) begin
            if (r_cnt == CNT_W'(TOTAL_RD - 1)) r_issued <= 1'b1;
            else                               r_cnt    <= r_cnt + 1'b1;
          end else if (!r_rd_vld) begin
            // Last read has been through the output register; pipeline is empty.
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (!iStart) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oLayer0_0 = r_out[0];
  assign oLayer0_1 = r_out[1];
  assign oLayer0_2 = r_out[2];
  assign oLayer0_3 = r_out[3];
  assign oValid    = r_valid;
  assign oDone     = r_done;

endmodule

// File: tb/tb_layer00_conv.sv
// Self-checking bench for layer00_conv: directed and random bank contents checked
// against a plain-arithmetic model of the convolution rules.
module tb_layer00_conv;
  import layer00_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  logic         iStart;
  logic [15:0]  i_ena;
  logic [8:0]   i_addra;
  logic [15:0]  i_wea;
  logic [127:0] i_dia;
  logic signed [15:0] bias_m [4];
  logic [7:0]   oLayer0_0, oLayer0_1, oLayer0_2, oLayer0_3;
  logic         oValid;
  logic         oDone;

  logic [127:0] mem_model [16][512];
  logic [31:0]  last_out;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  layer00_conv dut (
    .clk       (clk),
    .rstn      (rstn),
    .iStart    (iStart),
    .i_ena     (i_ena),
    .i_addra   (i_addra),
    .i_wea     (i_wea),
    .i_dia     (i_dia),
    .iBias0    (bias_m[0]),
    .iBias1    (bias_m[1]),
    .iBias2    (bias_m[2]),
    .iBias3    (bias_m[3]),
    .oLayer0_0 (oLayer0_0),
    .oLayer0_1 (oLayer0_1),
    .oLayer0_2 (oLayer0_2),
    .oLayer0_3 (oLayer0_3),
    .oValid    (oValid),
    .oDone     (oDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {oLayer0_3, oLayer0_2, oLayer0_1, oLayer0_0};
  endfunction

  // Reference: weighted pixel sum plus bias, divided by 2^SHIFT rounding toward
  // minus infinity, then clipped into 0..255.
  function automatic logic [31:0] ref_out(input logic [127:0] word);
    logic [31:0] r;
    int acc;
    int v;
    int s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int p = 0; p < 16; p++) acc += int'(word[8*p +: 8]) * int'(W[c][p]);
      v = acc + int'(bias_m[c]);
      s = (v >= 0) ? v / (1 << SHIFT) : -((-v + (1 << SHIFT) - 1) / (1 << SHIFT));
      if (s < 0)        r[8*c +: 8] = 8'd0;
      else if (s > 255) r[8*c +: 8] = 8'd255;
      else              r[8*c +: 8] = s[7:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    for (int p = 0; p < 16; p++)
      w[8*p +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic write_word(input logic [15:0] ena, input logic [15:0] wea,
                            input logic [8:0] addr, input logic [127:0] data);
    i_ena   = ena;
    i_wea   = wea;
    i_addra = addr;
    i_dia   = data;
    for (int b = 0; b < 16; b++)
      if (ena[b] && wea[b]) mem_model[b][addr] = data;
    @(negedge clk);
    i_ena = '0;
    i_wea = '0;
  endtask

  // One pass from IDLE; abort_at > 0 asserts reset in that cycle instead of finishing.
  task automatic run_pass(input string tag, input int abort_at, input bit mid_write);
    int cyc;
    int n;
    bit fin;
    logic [127:0] wd;
    cyc = 0;
    n   = 0;
    fin = 1'b0;
    iStart = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (mid_write && cyc == 10) begin
        wd = rand_word();
        i_ena = 16'h8000; i_wea = 16'h8000; i_addra = 9'd77; i_dia = wd;
        mem_model[15][77] = wd;
      end
      if (mid_write && cyc == 11) begin
        i_ena = '0; i_wea = '0;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        rstn = 1'b1;
        #1;
        check({tag, "_rst_out"}, outs(), 32'h0);
        check({tag, "_rst_flags"}, {30'b0, oDone, oValid}, 32'h0);
        @(negedge clk);
        rstn     = 1'b0;
        iStart   = 1'b0;
        last_out = '0;
        return;
      end
      if (oValid) begin
        if (n == 0) check({tag, "_latency"}, cyc, 3);
        last_out = ref_out(mem_model[n / 128][n % 128]);
        check($sformatf("%s_out%0d", tag, n), outs(), last_out);
        n++;
      end
      if (oDone) fin = 1'b1;
      else if (cyc > 2200) begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
        fin = 1'b1;
      end
    end
    check({tag, "_count"}, n, 2048);
    repeat (5) @(negedge clk);
    check({tag, "_hold_flags"}, {30'b0, oDone, oValid}, 32'h2);
    check({tag, "_hold_out"}, outs(), last_out);
    iStart = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {31'b0, oDone}, 32'h0);
  endtask

  initial begin
    rstn = 1'b1; iStart = 1'b0;
    i_ena = '0; i_wea = '0; i_addra = '0; i_dia = '0;
    for (int c = 0; c < 4; c++) bias_m[c] = '0;
    last_out = '0;
    repeat (3) @(negedge clk);
    check("reset_out", outs(), 32'h0);
    check("reset_flags", {30'b0, oDone, oValid}, 32'h0);
    rstn = 1'b0;
    @(negedge clk);

    // All-zero banks: only the biases reach the outputs.
    for (int a = 0; a < 128; a++) write_word(16'hFFFF, 16'hFFFF, 9'(a), '0);
    bias_m[0] = 16'h0100; bias_m[1] = 16'h0000; bias_m[2] = 16'hFF00; bias_m[3] = 16'h7FFF;
    run_pass("zero", 0, 1'b0);
    check("zero_const", outs(), 32'hFF00_0002);

    // Port enabled but write enable low must leave bank 2 untouched.
    write_word(16'h0004, 16'h0000, 9'd5, {16{8'hA5}});
    run_pass("no_we", 0, 1'b0);
    check("no_we_const", outs(), 32'hFF00_0002);

    // Single non-zero word; run twice to show a repeatable pass.
    for (int c = 0; c < 4; c++) bias_m[c] = '0;
    write_word(16'h0008, 16'h0008, 9'd5, {16{8'h01}});
    run_pass("single", 0, 1'b0);
    run_pass("single2", 0, 1'b0);

    // Random contents, multi-bank writes, a write during RUN, random biases.
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 128; a++) write_word(16'(1 << b), 16'(1 << b), 9'(a), rand_word());
    for (int k = 0; k < 64; k++)
      write_word(16'($urandom), 16'($urandom), 9'($urandom_range(0, 511)), rand_word());
    for (int c = 0; c < 4; c++) bias_m[c] = 16'($urandom_range(0, 8191) - 4096);
    run_pass("rand", 0, 1'b1);

    // Reset while read 1000 is issued, then a clean restart from bank 0 address 0.
    run_pass("abort", 1001, 1'b0);
    repeat (4) @(negedge clk);
    check("abort_idle", {30'b0, oDone, oValid}, 32'h0);
    run_pass("restart", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer00_conv.md
LAYER00_CONV -- requirements
Module: layer00_conv

Interface
REQ-001 The block SHALL expose `clk`, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL expose `rstn`, input, 1, an asynchronous active-high reset (the name is kept; the polarity is high).
REQ-003 The block SHALL expose `iStart`, input, 1, a level-sensitive run request.
REQ-004 The block SHALL expose `i_ena`, input, 16, the per-bank write-port enable.
REQ-005 The block SHALL expose `i_addra`, input, 9, the write address shared by all banks.
REQ-006 The block SHALL expose `i_wea`, input, 16, the per-bank write enable.
REQ-007 The block SHALL expose `i_dia`, input, 128, the write data: 16 unsigned 8-bit pixels, with pixel p at bits [8p+7:8p].
REQ-008 The block SHALL expose `iBias0`..`iBias3`, input, 16 each, the signed bias for output channels 0..3.
REQ-009 The block SHALL expose `oLayer0_0`..`oLayer0_3`, output, 8 each, the unsigned activation for channels 0..3.
REQ-010 The block SHALL expose `oValid`, output, 1, high for one cycle when `oLayer0_*` are updated.
REQ-011 The block SHALL expose `oDone`, output, 1, held high in the DONE state.

Function
REQ-012 The block SHALL contain 16 banks, each 512 x 128-bit, with one write port and one internal read port.
REQ-013 On a rising edge with `i_ena[b]` and `i_wea[b]` both high, the block SHALL write `i_dia` to bank b at `i_addra`; several banks may be written in the same cycle.
REQ-014 Writes SHALL be accepted in every state, including RUN.
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE.
- IDLE -> RUN when `iStart` = 1; the read counter clears to bank 0, address 0.
- RUN -> DONE after the last read is issued and the pipeline has drained.
- DONE -> IDLE when `iStart` = 0, so a held-high `iStart` triggers exactly one pass.
REQ-016 In RUN, the block SHALL issue one read per cycle, covering addresses 0..127 of bank 0, then bank 1, and so on to bank 15, for 2048 reads per pass.
REQ-017 The read latency SHALL be 1 cycle and the MAC plus output register 1 cycle, so outputs and `oValid` appear 2 cycles after the read address is issued.
REQ-018 For each channel c, the block SHALL compute acc = sum over p=0..15 of (pixel p, zero-extended) times W[c][p] (signed 8-bit), held as a 21-bit signed value.
REQ-019 The block SHALL then compute s = (acc + sign-extended `iBias_c`) >>> SHIFT, where SHIFT = 7 and the shift is arithmetic.
REQ-020 The output SHALL be oLayer0_c = 0 if s < 0, 255 if s > 255, and s[7:0] otherwise (ReLU plus saturation).
REQ-021 `iBias*` SHALL be sampled every cycle, so callers must hold it stable during RUN.
REQ-022 `oLayer0_*` SHALL hold their last value between `oValid` pulses and after DONE.
REQ-023 `oDone` SHALL be 1 exactly while in DONE.

Reset
REQ-024 Asserting `rstn` = 1 SHALL force IDLE, clear the counters, set `oLayer0_*` = 0 and clear `oValid` and `oDone`, including mid-RUN.
REQ-025 Bank contents SHALL NOT be reset.

Structure
REQ-026 The package `layer00_pkg` SHALL hold NUM_BANK=16, BANK_DEPTH=512, SCAN_DEPTH=128, DATA_W=128, PIX_W=8, NUM_CH=4, SHIFT=7, the weight table W[4][16] (signed 8-bit) and the FSM state enum.
REQ-027 The banks SHALL be built from one sub-module, `layer00_bram` (simple dual-port, registered read), instantiated 16 times.

Verification
REQ-028 Load all banks with zeros, set bias0..3 = 0x0100, 0x0000, 0xFF00, 0x7FFF, assert `iStart` -> every output is (2, 0, 0, 255) and `oValid` pulses 2048 times.
REQ-029 Write bank 3, address 5 with all pixels = 0x01 and all other words zero, bias = 0 -> the output at pass index 3*128+5 equals clamp((sum_p W[c][p]) >>> 7), and all others are 0.
REQ-030 Drive `i_ena`=0x0004 with `i_wea`=0x0000 and non-zero data -> bank 2 is unchanged and the outputs match the all-zero result.
REQ-031 Hold `iStart` high -> exactly one pass, then `oDone`=1; drop `iStart` -> IDLE; raise it again -> a second identical pass.
REQ-032 Assert `rstn` at read 1000 -> outputs go to 0 and the FSM to IDLE immediately; after release and `iStart` the pass restarts at bank 0, address 0.
REQ-033 Check timing: the first `oValid` is exactly 3 cycles after the cycle in which `iStart` is sampled in IDLE.
